// File: rtl/i2c_target.sv
// I2C target emulating a byte-addressed sensor register file behind a 7-bit address.
// Auto-incrementing register pointer; data bytes can be preloaded from a host port.
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1D,
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        scl,
    inout  wire                         sda,
    input  logic                        host_we,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    input  logic [7:0]                  host_data,
    output logic                        bus_wr,
    output logic [$clog2(NUM_REGS)-1:0] bus_wr_addr,
    output logic [7:0]                  bus_wr_data,
    output logic                        busy
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        WAIT
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    logic                   rw_q;
    logic                   ack_q;
    logic                   sda_oe_q;
    logic [AW-1:0]          ptr_q;
    logic [7:0]             regs_q [NUM_REGS];
    logic                   bus_wr_q;
    logic [AW-1:0]          bus_wr_addr_q;
    logic [7:0]             bus_wr_data_q;
    logic                   busy_q;

    logic          scl_s;
    logic          sda_s;
    logic          scl_rise_c;
    logic          scl_fall_c;
    logic          start_c;
    logic          stop_c;
    logic [7:0]    rx_byte_c;
    logic [AW-1:0] ptr_inc_c;

    // Bus conditions are judged only from the synchronized samples
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_c = ~scl_prev_q & scl_s;
    assign scl_fall_c = scl_prev_q & ~scl_s;
    assign start_c    = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
    assign stop_c     = scl_prev_q & scl_s & ~sda_prev_q & sda_s;
    assign rx_byte_c  = {shift_q[6:0], sda_s};
    assign ptr_inc_c  = ptr_q + AW'(1);

    assign sda         = sda_oe_q ? 1'b0 : 1'bz;
    assign bus_wr      = bus_wr_q;
    assign bus_wr_addr = bus_wr_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign busy        = busy_q;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q       <= IDLE;
            scl_sync_q    <= '1;
            sda_sync_q    <= '1;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            shift_q       <= 8'h00;
            bit_cnt_q     <= 3'd0;
            rw_q          <= 1'b0;
            ack_q         <= 1'b0;
            sda_oe_q      <= 1'b0;
            ptr_q         <= '0;
            bus_wr_q      <= 1'b0;
            bus_wr_addr_q <= '0;
            bus_wr_data_q <= 8'h00;
            busy_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[AW'(i)] <= 8'h00;
            end
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            bus_wr_q   <= 1'b0;

            // Host write first so a same-cycle bus write to the same register wins
            if (host_we) begin
                regs_q[host_addr] <= host_data;
            end

            if (start_c) begin
                state_q   <= ADDR;
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
                ack_q     <= 1'b0;
            end else if (stop_c) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                ack_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise_c) begin
                            shift_q   <= rx_byte_c;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (rx_byte_c[7:1] == DEV_ADDR) begin
                                    state_q <= ADDR_ACK;
                                    rw_q    <= rx_byte_c[0];
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    // ACK states: first falling edge drives low, second releases
                    ADDR_ACK: begin
                        if (scl_fall_c) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= 3'd0;
                                if (rw_q) begin
                                    state_q  <= RDATA;
                                    shift_q  <= regs_q[ptr_q];
                                    sda_oe_q <= ~regs_q[ptr_q][7];
                                end else begin
                                    state_q  <= PTR;
                                    sda_oe_q <= 1'b0;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise_c) begin
                            shift_q   <= rx_byte_c;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                ptr_q   <= rx_byte_c[AW-1:0];
                                state_q <= PTR_ACK;
                            end
                        end
                    end
                    PTR_ACK, WACK: begin
                        if (scl_fall_c) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise_c) begin
                            shift_q   <= rx_byte_c;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                regs_q[ptr_q] <= rx_byte_c;
                                bus_wr_q      <= 1'b1;
                                bus_wr_addr_q <= ptr_q;
                                bus_wr_data_q <= rx_byte_c;
                                ptr_q         <= ptr_inc_c;
                                state_q       <= WACK;
                            end
                        end
                    end
                    // Only 0 bits are driven; 1 bits leave the line to the pull-up
                    RDATA: begin
                        if (scl_rise_c) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                ptr_q   <= ptr_inc_c;
                                ack_q   <= 1'b0;
                                state_q <= RACK;
                            end
                        end else if (scl_fall_c) begin
                            shift_q  <= {shift_q[6:0], 1'b0};
                            sda_oe_q <= ~shift_q[6];
                        end
                    end
                    RACK: begin
                        if (scl_rise_c) begin
                            if (sda_s) begin
                                state_q <= WAIT;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end else if (scl_fall_c) begin
                            if (ack_q) begin
                                ack_q     <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                shift_q   <= regs_q[ptr_q];
                                sda_oe_q  <= ~regs_q[ptr_q][7];
                                state_q   <= RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master with hand-computed expectations.
module tb_i2c_target;

    localparam int unsigned Q = 40;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       scl_r = 1'b1;
    logic       sda_low = 1'b0;
    logic       host_we = 1'b0;
    logic [5:0] host_addr = '0;
    logic [7:0] host_data = '0;
    logic       bus_wr;
    logic [5:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;
    wire        sda_w;

    pullup (sda_w);
    assign sda_w = sda_low ? 1'b0 : 1'bz;

    always #5 CLK = ~CLK;

    i2c_target dut (
        .CLK         (CLK),
        .rst         (rst),
        .scl         (scl_r),
        .sda         (sda_w),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .bus_wr      (bus_wr),
        .bus_wr_addr (bus_wr_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];

    always @(negedge CLK) begin
        if (bus_wr) begin
            wr_addr_log.push_back({2'b00, bus_wr_addr});
            wr_data_log.push_back(bus_wr_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; #Q;
        scl_r   = 1'b1; #Q;
        sda_low = 1'b1; #Q;
        scl_r   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; #Q;
        scl_r   = 1'b1; #Q;
        sda_low = 1'b0; #Q;
        #Q;
    endtask

    task automatic bit_out(input logic b);
        sda_low = ~b; #Q;
        scl_r   = 1'b1; #Q;
        #Q;
        scl_r   = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0; #Q;
        scl_r   = 1'b1; #Q;
        b       = sda_w; #Q;
        scl_r   = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_in(s);
            b[i] = s;
        end
        bit_out(~ack);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge CLK);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(negedge CLK);
        host_we = 1'b0;
    endtask

    // Pointer write, repeated START, then read one or two bytes
    task automatic rd_at(input logic [7:0] p, input int n, output logic [7:0] d0, output logic [7:0] d1);
        logic a;
        d1 = 8'h00;
        i2c_start();
        write_byte(8'h3A, a); check_eq("rd_addr_w_ack", 32'(a), 32'd1);
        write_byte(p, a);     check_eq("rd_ptr_ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'h3B, a); check_eq("rd_addr_r_ack", 32'(a), 32'd1);
        read_byte(d0, n > 1);
        if (n > 1) read_byte(d1, 1'b0);
        i2c_stop();
    endtask

    initial begin
        logic       a;
        logic [7:0] d0, d1;

        // Reset
        @(negedge CLK); @(negedge CLK);
        check_eq("reset_sda", 32'(sda_w), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_bus_wr", 32'(bus_wr), 32'd0);
        rst = 1'b1;
        @(negedge CLK);
        rd_at(8'h00, 1, d0, d1);
        check_eq("reset_reg00", 32'(d0), 32'h00);

        // Write two bytes from pointer 0x2D
        wr_addr_log.delete(); wr_data_log.delete();
        i2c_start();
        write_byte(8'h3A, a); check_eq("wr_addr_ack", 32'(a), 32'd1);
        check_eq("wr_busy", 32'(busy), 32'd1);
        write_byte(8'h2D, a); check_eq("wr_ptr_ack", 32'(a), 32'd1);
        write_byte(8'h08, a); check_eq("wr_d0_ack", 32'(a), 32'd1);
        write_byte(8'h55, a); check_eq("wr_d1_ack", 32'(a), 32'd1);
        i2c_stop();
        check_eq("wr_busy_after_p", 32'(busy), 32'd0);
        check_eq("wr_pulses", 32'(wr_addr_log.size()), 32'd2);
        if (wr_addr_log.size() == 2) begin
            check_eq("wr_p0_addr", 32'(wr_addr_log[0]), 32'h2D);
            check_eq("wr_p0_data", 32'(wr_data_log[0]), 32'h08);
            check_eq("wr_p1_addr", 32'(wr_addr_log[1]), 32'h2E);
            check_eq("wr_p1_data", 32'(wr_data_log[1]), 32'h55);
        end
        // Pointer left at 0x2F: a plain read returns reg[0x2F]
        host_write(6'h2F, 8'h9C);
        i2c_start();
        write_byte(8'h3B, a); check_eq("ptr_rd_ack", 32'(a), 32'd1);
        read_byte(d0, 1'b0);
        i2c_stop();
        check_eq("ptr_after_wr", 32'(d0), 32'h9C);
        rd_at(8'h2D, 2, d0, d1);
        check_eq("wr_readback_2d", 32'(d0), 32'h08);
        check_eq("wr_readback_2e", 32'(d1), 32'h55);

        // Host preload then read with repeated START
        host_write(6'h32, 8'hA7);
        host_write(6'h33, 8'h01);
        i2c_start();
        write_byte(8'h3A, a); check_eq("sr_addr_w_ack", 32'(a), 32'd1);
        write_byte(8'h32, a); check_eq("sr_ptr_ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'h3B, a); check_eq("sr_addr_r_ack", 32'(a), 32'd1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b0);
        check_eq("sr_busy_before_p", 32'(busy), 32'd1);
        i2c_stop();
        check_eq("sr_byte0", 32'(d0), 32'hA7);
        check_eq("sr_byte1", 32'(d1), 32'h01);
        check_eq("sr_busy_after_p", 32'(busy), 32'd0);

        // Address miss
        wr_addr_log.delete(); wr_data_log.delete();
        i2c_start();
        write_byte(8'h40, a); check_eq("miss_no_ack", 32'(a), 32'd0);
        check_eq("miss_busy", 32'(busy), 32'd0);
        write_byte(8'h12, a); check_eq("miss_data_no_ack", 32'(a), 32'd0);
        i2c_stop();
        check_eq("miss_no_pulse", 32'(wr_addr_log.size()), 32'd0);

        // Pointer wrap on write
        wr_addr_log.delete(); wr_data_log.delete();
        i2c_start();
        write_byte(8'h3A, a); check_eq("wrap_addr_ack", 32'(a), 32'd1);
        write_byte(8'h3F, a); check_eq("wrap_ptr_ack", 32'(a), 32'd1);
        write_byte(8'h11, a); check_eq("wrap_d0_ack", 32'(a), 32'd1);
        write_byte(8'h22, a); check_eq("wrap_d1_ack", 32'(a), 32'd1);
        i2c_stop();
        check_eq("wrap_pulses", 32'(wr_addr_log.size()), 32'd2);
        if (wr_addr_log.size() == 2) begin
            check_eq("wrap_p0_addr", 32'(wr_addr_log[0]), 32'h3F);
            check_eq("wrap_p1_addr", 32'(wr_addr_log[1]), 32'h00);
            check_eq("wrap_p1_data", 32'(wr_data_log[1]), 32'h22);
        end
        host_write(6'h01, 8'h5E);
        i2c_start();
        write_byte(8'h3B, a); check_eq("wrap_rd_ack", 32'(a), 32'd1);
        read_byte(d0, 1'b0);
        i2c_stop();
        check_eq("wrap_ptr_01", 32'(d0), 32'h5E);
        rd_at(8'h3F, 2, d0, d1);
        check_eq("wrap_reg3f", 32'(d0), 32'h11);
        check_eq("wrap_reg00", 32'(d1), 32'h22);
        // Upper pointer bits ignored: 0xC5 selects reg 0x05
        host_write(6'h05, 8'h77);
        rd_at(8'hC5, 1, d0, d1);
        check_eq("ptr_upper_ignored", 32'(d0), 32'h77);

        // STOP after a partial data byte
        wr_addr_log.delete(); wr_data_log.delete();
        i2c_start();
        write_byte(8'h3A, a); check_eq("part_addr_ack", 32'(a), 32'd1);
        write_byte(8'h10, a); check_eq("part_ptr_ack", 32'(a), 32'd1);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        i2c_stop();
        check_eq("part_no_pulse", 32'(wr_addr_log.size()), 32'd0);
        check_eq("part_busy", 32'(busy), 32'd0);
        rd_at(8'h10, 1, d0, d1);
        check_eq("part_reg10", 32'(d0), 32'h00);

        // Reset in the middle of a read while the target drives a 0 bit
        i2c_start();
        write_byte(8'h3A, a); check_eq("abort_addr_ack", 32'(a), 32'd1);
        write_byte(8'h20, a); check_eq("abort_ptr_ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'h3B, a); check_eq("abort_addr_r_ack", 32'(a), 32'd1);
        bit_in(a); bit_in(a);
        check_eq("abort_sda_driven", 32'(sda_w), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        @(posedge CLK); #1;
        check_eq("abort_sda_released", 32'(sda_w), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        i2c_stop();
        rd_at(8'h2D, 1, d0, d1);
        check_eq("abort_regs_cleared", 32'(d0), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
